// File: rtl/alu_issue_sched.sv
// Collapsing ALU issue queue: tag wakeup, oldest-ready select, flush.
// Optional feature: define ALU_ISSUE_BYPASS_EN for same-cycle wakeup-to-issue bypass.
module alu_issue_sched #(
    parameter int unsigned DEPTH         = 4,
    parameter int unsigned TAG_WD        = 4,
    parameter int unsigned INST_STATE_WD = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [11:0]                  in_op,
    input  logic [INST_STATE_WD-1:0]     in_inst_status,
    input  logic                         in_src1_rdy,
    input  logic                         in_src2_rdy,
    input  logic [TAG_WD-1:0]            in_src1_tag,
    input  logic [TAG_WD-1:0]            in_src2_tag,
    input  logic [31:0]                  in_rdata1,
    input  logic [31:0]                  in_rdata2,
    input  logic                         wb_valid,
    input  logic [TAG_WD-1:0]            wb_tag,
    input  logic [31:0]                  wb_data,
    output logic                         fu_ready,
    output logic [11:0]                  fu_op,
    output logic [INST_STATE_WD-1:0]     fu_inst_status,
    output logic [31:0]                  fu_rdata1,
    output logic [31:0]                  fu_rdata2,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned IW = $clog2(DEPTH);

    typedef struct packed {
        logic                     valid;
        logic [11:0]              op;
        logic [INST_STATE_WD-1:0] status;
        logic                     rdy1;
        logic [TAG_WD-1:0]        tag1;
        logic [31:0]              data1;
        logic                     rdy2;
        logic [TAG_WD-1:0]        tag2;
        logic [31:0]              data2;
    } entry_t;

    entry_t          q       [DEPTH];
    entry_t          woke    [DEPTH];
    entry_t          shifted [DEPTH];
    entry_t          q_nxt   [DEPTH];
    entry_t          incoming;
    logic [31:0]     op1     [DEPTH];
    logic [31:0]     op2     [DEPTH];
    logic [DEPTH-1:0] hit1;
    logic [DEPTH-1:0] hit2;
    logic [DEPTH-1:0] cand;
    logic            found;
    logic            iss;
    logic            enq;
    logic [IW-1:0]   sel;
    logic [CW-1:0]   pos;
    logic [CW-1:0]   count_nxt;

    // Wakeup matching and per-entry issue eligibility
    always_comb begin
        hit1 = '0;
        hit2 = '0;
        cand = '0;
        for (int i = 0; i < DEPTH; i++) begin
            woke[i] = q[i];
            hit1[i] = q[i].valid & ~q[i].rdy1 & wb_valid & (q[i].tag1 == wb_tag);
            hit2[i] = q[i].valid & ~q[i].rdy2 & wb_valid & (q[i].tag2 == wb_tag);
            if (hit1[i]) begin
                woke[i].rdy1  = 1'b1;
                woke[i].data1 = wb_data;
            end
            if (hit2[i]) begin
                woke[i].rdy2  = 1'b1;
                woke[i].data2 = wb_data;
            end
`ifdef ALU_ISSUE_BYPASS_EN
            cand[i] = q[i].valid & (q[i].rdy1 | hit1[i]) & (q[i].rdy2 | hit2[i]);
            op1[i]  = q[i].rdy1 ? q[i].data1 : wb_data;
            op2[i]  = q[i].rdy2 ? q[i].data2 : wb_data;
`else
            cand[i] = q[i].valid & q[i].rdy1 & q[i].rdy2;
            op1[i]  = q[i].data1;
            op2[i]  = q[i].data2;
`endif
        end
    end

    // Oldest-ready select; outputs forced to zero when nothing issues
    always_comb begin
        found          = 1'b0;
        sel            = '0;
        fu_op          = '0;
        fu_inst_status = '0;
        fu_rdata1      = '0;
        fu_rdata2      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!found && cand[i]) begin
                found          = 1'b1;
                sel            = IW'(i);
                fu_op          = q[i].op;
                fu_inst_status = q[i].status;
                fu_rdata1      = op1[i];
                fu_rdata2      = op2[i];
            end
        end
        iss      = found & ~flush & ~reset;
        fu_ready = iss;
        if (!iss) begin
            fu_op          = '0;
            fu_inst_status = '0;
            fu_rdata1      = '0;
            fu_rdata2      = '0;
        end
    end

    // Enqueue handshake and incoming entry with writeback snoop
    always_comb begin
        in_ready = ~reset & ~flush & (count < CW'(DEPTH));
        enq      = in_valid & in_ready;
        pos      = count - CW'(iss);

        incoming.valid  = 1'b1;
        incoming.op     = in_op;
        incoming.status = in_inst_status;
        incoming.rdy1   = in_src1_rdy;
        incoming.tag1   = in_src1_tag;
        incoming.data1  = in_rdata1;
        incoming.rdy2   = in_src2_rdy;
        incoming.tag2   = in_src2_tag;
        incoming.data2  = in_rdata2;
        if (!in_src1_rdy && wb_valid && (in_src1_tag == wb_tag)) begin
            incoming.rdy1  = 1'b1;
            incoming.data1 = wb_data;
        end
        if (!in_src2_rdy && wb_valid && (in_src2_tag == wb_tag)) begin
            incoming.rdy2  = 1'b1;
            incoming.data2 = wb_data;
        end
    end

    // Collapse above the issued slot, then place the new entry at the tail
    always_comb begin
        for (int i = 0; i < DEPTH - 1; i++) begin
            shifted[i] = woke[i+1];
        end
        shifted[DEPTH-1] = '0;
        for (int i = 0; i < DEPTH; i++) begin
            q_nxt[i] = (iss && (IW'(i) >= sel)) ? shifted[i] : woke[i];
            if (enq && (CW'(i) == pos)) begin
                q_nxt[i] = incoming;
            end
            if (flush) begin
                q_nxt[i].valid = 1'b0;
            end
        end
        count_nxt = flush ? '0 : (count + CW'(enq) - CW'(iss));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                q[i].valid <= 1'b0;
            end
        end else begin
            count <= count_nxt;
            for (int i = 0; i < DEPTH; i++) begin
                q[i] <= q_nxt[i];
            end
        end
    end

endmodule

// File: doc/alu_issue_sched.md
ALU_ISSUE_SCHED -- requirements
Module: alu_issue_sched

Interface
REQ-001 Parameter: DEPTH, 4, number of queue entries (2..8).
REQ-002 Parameter: TAG_WD, 4, width of producer (ROB) tags.
REQ-003 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Port: reset  input  1  reset, synchronous and active-high.
REQ-005 Port: flush  input  1  pipeline flush; discards all queued entries.
REQ-006 Port: in_valid  input  1  enqueue request.
REQ-007 Port: in_ready  output  1  enqueue accepted when in_valid & in_ready.
REQ-008 Port: in_op  input  12  ALU one-hot control.
REQ-009 Port: in_inst_status  input  INST_STATE_WD  instruction status word (SEL1/SEL2/IMM/WE fields).
REQ-010 Port: in_src1_rdy, in_src2_rdy  input  1 each  operand already valid.
REQ-011 Port: in_src1_tag, in_src2_tag  input  TAG_WD each  producer tag of a pending operand.
REQ-012 Port: in_rdata1, in_rdata2  input  32 each  operand values (meaningful when rdy).
REQ-013 Port: wb_valid  input  1  writeback broadcast valid.
REQ-014 Port: wb_tag  input  TAG_WD  writeback producer tag.
REQ-015 Port: wb_data  input  32  writeback value.
REQ-016 Port: fu_ready  output  1  issue strobe to the ALU unit's ready input.
REQ-017 Port: fu_op  output  12  issued op.
REQ-018 Port: fu_inst_status  output  INST_STATE_WD  issued status word.
REQ-019 Port: fu_rdata1, fu_rdata2  output  32 each  issued operands.
REQ-020 Port: count  output  clog2(DEPTH+1)  occupied entries.

Function
REQ-021 Queue SHALL be collapsing: entry 0 oldest; occupied entries always contiguous from 0.
REQ-022 Entry SHALL hold valid, op, inst_status, per-source rdy/tag/data.
REQ-023 in_ready SHALL equal (count < DEPTH) & ~flush, from registered count only (no credit for same-cycle issue).
REQ-024 Accepted entry SHALL be written at position count minus 1 if an issue occurs that cycle, else count; visible for selection the next cycle (min enqueue-to-issue latency 1 cycle).
REQ-025 Wakeup: each valid entry source with rdy=0 and tag==wb_tag while wb_valid SHALL set rdy=1 and capture wb_data at the edge.
REQ-026 Enqueue SHALL snoop wakeup: incoming source with rdy=0 and tag==wb_tag while wb_valid SHALL be stored rdy=1 with wb_data.
REQ-027 Select: lowest-index valid entry with both sources ready SHALL issue; at most one issue per cycle.
REQ-028 fu_ready SHALL be 1 exactly in the issuing cycle; fu_op/fu_inst_status/fu_rdata1/2 SHALL carry the selected entry combinationally; all outputs SHALL be zero when no issue.
REQ-029 Issued entry SHALL be removed at the edge; entries above shift down by one, preserving order and wakeup captured that cycle.
REQ-030 flush SHALL force fu_ready=0 and all fu_* to zero that cycle, block enqueue, and clear every valid bit at the edge; flush beats enqueue, issue and wakeup.
REQ-031 count SHALL update as count + enq - iss each cycle; never exceed DEPTH or underflow.
REQ-032 Full and simultaneous issue: in_ready remains 0 that cycle; slot frees next cycle.

Reset
REQ-033 reset SHALL clear all valid bits and count to 0 at the edge; data fields need not clear.
REQ-034 While reset is high, in_ready, fu_ready and all fu_* SHALL be 0; reset beats flush.

Configuration
REQ-035 Macro ALU_ISSUE_BYPASS_EN defined: an entry whose last pending source matches the current wakeup SHALL be selectable that cycle, with wb_data substituted for the operand on fu_rdata; not defined: wakeup takes effect only from the next cycle (issue >= 1 cycle after wb).

Verification
REQ-036 reset, enqueue op=12'h001, both rdy, rdata1=5, rdata2=7 at T -> fu_ready=1 at T+1 with fu_rdata1=5, fu_rdata2=7; count 1 then 0.
REQ-037 Enqueue A(src1 tag 3 pending) then B(ready) -> B issues first; wb_valid tag=3 data=32'hDEAD -> A issues with fu_rdata1=32'hDEAD next cycle (same cycle if ALU_ISSUE_BYPASS_EN).
REQ-038 Fill DEPTH=4 entries all pending -> in_ready=0, count=4, fu_ready=0; wake entry 2 -> it issues, entries 3 shifts to 2, in_ready=1 next cycle.
REQ-039 Enqueue with in_src2_tag=5 pending while wb_valid tag=5 data=9 same cycle -> entry stored ready, issues next cycle with fu_rdata2=9.
REQ-040 Queue holds 3 entries, flush with simultaneous in_valid and ready entry -> fu_ready=0 that cycle, count=0 next cycle, nothing issues afterward.
